// File: rtl/u_xmit_param.sv
// u_xmit_param: parametrised UART transmitter.
//   Frame: start(0), DATA_W data bits LSB first, optional parity, 1 or 2
//   stop bits. Bit period = TICKS_PER_BIT * CLOCK_DIVIDE sys_clk cycles,
//   phase-locked to frame acceptance.
// Ports:
//   sys_clk          master clock
//   sys_rst_I        asynchronous active-low reset
//   xmitH            transmit request, sampled only while idle
//   xmit_dataH       word to send (latched on acceptance)
//   parity_modeH     00 none, 01 even, 10 odd, 11 none (latched)
//   stop2H           0 one stop bit, 1 two stop bits (latched)
//   breakH           (UART_TX_BREAK_EN only) hold line low / break request
//   uart_XMIT_dataH  serial line, idle high, flop driven
//   xmit_busyH       high while a frame is in progress
//   xmit_doneH       one-cycle pulse at end of frame
// Optional feature macro: UART_TX_BREAK_EN adds breakH and a BREAK state.
module u_xmit_param #(
  parameter int CLOCK_DIVIDE  = 1302,
  parameter int TICKS_PER_BIT = 4,
  parameter int DATA_W        = 8
) (
  input  logic              sys_clk,
  input  logic              sys_rst_I,
  input  logic              xmitH,
  input  logic [DATA_W-1:0] xmit_dataH,
  input  logic [1:0]        parity_modeH,
  input  logic              stop2H,
`ifdef UART_TX_BREAK_EN
  input  logic              breakH,
`endif
  output logic              uart_XMIT_dataH,
  output logic              xmit_busyH,
  output logic              xmit_doneH
);

  generate
    if (CLOCK_DIVIDE < 1 || CLOCK_DIVIDE > 2047) begin : g_bad_cd
      $error("u_xmit_param: CLOCK_DIVIDE out of range 1..2047");
    end
    if (TICKS_PER_BIT < 1 || TICKS_PER_BIT > 15) begin : g_bad_tpb
      $error("u_xmit_param: TICKS_PER_BIT out of range 1..15");
    end
    if (DATA_W < 5 || DATA_W > 9) begin : g_bad_dw
      $error("u_xmit_param: DATA_W out of range 5..9");
    end
  endgenerate

  localparam logic [10:0] DIV_M1  = 11'(CLOCK_DIVIDE - 1);
  localparam logic [3:0]  TICK_M1 = 4'(TICKS_PER_BIT - 1);
  localparam logic [3:0]  LAST_DB = 4'(DATA_W - 1);

  typedef enum logic [2:0] {
    IDLE, START, DATA, PARITY, STOP
`ifdef UART_TX_BREAK_EN
    , BREAK
`endif
  } state_e;

  state_e              state_q;
  logic [10:0]         div_q, div_d;
  logic [3:0]          tick_q;
  logic [3:0]          bit_q;
  logic [DATA_W-1:0]   shift_q;
  logic                par_en_q, par_bit_q, stop2_q;
  logic                line_q, busy_q, done_q;
  logic                tick, bit_end;

  // Divider idles at its reload value, so acceptance always starts a full
  // tick and every bit edge lands TICKS_PER_BIT*CLOCK_DIVIDE cycles apart.
  always_comb begin
    div_d = DIV_M1;
    if (state_q != IDLE && div_q != 11'd0) div_d = div_q - 11'd1;
  end

  assign tick    = (state_q != IDLE) && (div_q == 11'd0);
  assign bit_end = tick && (tick_q == TICK_M1);

  always_ff @(posedge sys_clk or negedge sys_rst_I) begin
    if (!sys_rst_I) begin
      state_q   <= IDLE;
      div_q     <= DIV_M1;
      tick_q    <= 4'd0;
      bit_q     <= 4'd0;
      shift_q   <= '0;
      par_en_q  <= 1'b0;
      par_bit_q <= 1'b0;
      stop2_q   <= 1'b0;
      line_q    <= 1'b1;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      div_q  <= div_d;
      if (tick) tick_q <= bit_end ? 4'd0 : tick_q + 4'd1;
      case (state_q)
        IDLE: begin
`ifdef UART_TX_BREAK_EN
          if (breakH) begin
            line_q  <= 1'b0;
            busy_q  <= 1'b1;
            tick_q  <= 4'd0;
            bit_q   <= 4'd0;
            state_q <= BREAK;
          end else
`endif
          if (xmitH) begin
            shift_q   <= xmit_dataH;
            par_en_q  <= (parity_modeH == 2'b01) || (parity_modeH == 2'b10);
            par_bit_q <= (^xmit_dataH) ^ (parity_modeH == 2'b10);
            stop2_q   <= stop2H;
            line_q    <= 1'b0;
            busy_q    <= 1'b1;
            tick_q    <= 4'd0;
            bit_q     <= 4'd0;
            state_q   <= START;
          end
        end
        START: if (bit_end) begin
          line_q  <= shift_q[0];
          shift_q <= shift_q >> 1;
          bit_q   <= 4'd0;
          state_q <= DATA;
        end
        DATA: if (bit_end) begin
          if (bit_q == LAST_DB) begin
            bit_q <= 4'd0;
            if (par_en_q) begin
              line_q  <= par_bit_q;
              state_q <= PARITY;
            end else begin
              line_q  <= 1'b1;
              state_q <= STOP;
            end
          end else begin
            line_q  <= shift_q[0];
            shift_q <= shift_q >> 1;
            bit_q   <= bit_q + 4'd1;
          end
        end
        PARITY: if (bit_end) begin
          line_q  <= 1'b1;
          bit_q   <= 4'd0;
          state_q <= STOP;
        end
        STOP: if (bit_end) begin
          if (stop2_q && bit_q == 4'd0) begin
            bit_q <= 4'd1;
          end else begin
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= IDLE;
          end
        end
`ifdef UART_TX_BREAK_EN
        // Line held low for at least start+DATA_W+stop bit periods; release
        // only on a bit boundary, then one stop-length mark via STOP.
        BREAK: if (bit_end) begin
          if (bit_q >= 4'(DATA_W + 1) && !breakH) begin
            line_q  <= 1'b1;
            stop2_q <= 1'b0;
            bit_q   <= 4'd0;
            state_q <= STOP;
          end else if (bit_q < 4'(DATA_W + 1)) begin
            bit_q <= bit_q + 4'd1;
          end
        end
`endif
        default: state_q <= IDLE;
      endcase
    end
  end

  assign uart_XMIT_dataH = line_q;
  assign xmit_busyH      = busy_q;
  assign xmit_doneH      = done_q;

endmodule

// File: tb/tb_u_xmit_param.sv
// Testbench for u_xmit_param (CLOCK_DIVIDE=4, TICKS_PER_BIT=4, DATA_W=8).
// Expected line waveform is built from the frame's bit list (start, data
// LSB first, parity, stops) expanded to 16 cycles per bit.
module tb_u_xmit_param;
  localparam int CD  = 4;
  localparam int TPB = 4;
  localparam int DW  = 8;
  localparam int BIT = CD * TPB;

  logic          sys_clk = 1'b0;
  logic          sys_rst_I;
  logic          xmitH;
  logic [DW-1:0] xmit_dataH;
  logic [1:0]    parity_modeH;
  logic          stop2H;
`ifdef UART_TX_BREAK_EN
  logic          breakH;
`endif
  logic          uart_XMIT_dataH, xmit_busyH, xmit_doneH;

  int n_checks = 0;
  int n_errors = 0;

  u_xmit_param #(.CLOCK_DIVIDE(CD), .TICKS_PER_BIT(TPB), .DATA_W(DW)) dut (
    .sys_clk        (sys_clk),
    .sys_rst_I      (sys_rst_I),
    .xmitH          (xmitH),
    .xmit_dataH     (xmit_dataH),
    .parity_modeH   (parity_modeH),
    .stop2H         (stop2H),
`ifdef UART_TX_BREAK_EN
    .breakH         (breakH),
`endif
    .uart_XMIT_dataH(uart_XMIT_dataH),
    .xmit_busyH     (xmit_busyH),
    .xmit_doneH     (xmit_doneH)
  );

  always #5 sys_clk = ~sys_clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic idle(input int n, input string tag);
    for (int i = 0; i < n; i++) begin
      @(negedge sys_clk);
      check($sformatf("%s.line", tag), 32'(uart_XMIT_dataH), 32'd1);
      check($sformatf("%s.busy", tag), 32'(xmit_busyH), 32'd0);
      check($sformatf("%s.done", tag), 32'(xmit_doneH), 32'd0);
    end
  endtask

  // Called just after a negedge. Requests a frame and checks every cycle
  // from the acceptance edge (k=0) to the done edge (k=L). hold keeps xmitH
  // high so the next call is accepted in the done cycle. abort_at>=0 drops
  // reset at that cycle instead of finishing the frame.
  task automatic frame(input logic [DW-1:0] d, input logic [1:0] m, input logic s2,
                       input bit hold, input int abort_at, input int fn);
    bit q[$];
    int L;
    logic el;
    xmitH = 1'b1; xmit_dataH = d; parity_modeH = m; stop2H = s2;
    q.push_back(1'b0);
    for (int i = 0; i < DW; i++) q.push_back(d[i]);
    if (m == 2'b01) q.push_back(^d);
    if (m == 2'b10) q.push_back(~^d);
    q.push_back(1'b1);
    if (s2) q.push_back(1'b1);
    L = q.size() * BIT;
    for (int k = 0; k <= L; k++) begin
      @(negedge sys_clk);
      el = (k < L) ? q[k / BIT] : 1'b1;
      check($sformatf("f%0d.line@%0d", fn, k), 32'(uart_XMIT_dataH), 32'(el));
      check($sformatf("f%0d.busy@%0d", fn, k), 32'(xmit_busyH), 32'(k < L));
      check($sformatf("f%0d.done@%0d", fn, k), 32'(xmit_doneH), 32'(k == L));
      if (k == abort_at) begin
        xmitH = 1'b0;
        sys_rst_I = 1'b0;
        #1;
        check("rst.line", 32'(uart_XMIT_dataH), 32'd1);
        check("rst.busy", 32'(xmit_busyH), 32'd0);
        check("rst.done", 32'(xmit_doneH), 32'd0);
        break;
      end
      // Latched inputs must not matter mid-frame; xmitH pulses are ignored.
      if (k < L) begin
        xmit_dataH   = DW'($urandom);
        parity_modeH = 2'($urandom);
        stop2H       = 1'($urandom);
        if (!hold) xmitH = (k > 0 && k < L - 1) ? 1'($urandom) : 1'b0;
      end else if (!hold) begin
        xmitH = 1'b0;
      end
    end
  endtask

  initial begin
    bit h;
    sys_rst_I = 1'b0; xmitH = 1'b0; xmit_dataH = '0; parity_modeH = 2'b00; stop2H = 1'b0;
`ifdef UART_TX_BREAK_EN
    breakH = 1'b0;
`endif
    repeat (3) @(negedge sys_clk);
    check("reset.line", 32'(uart_XMIT_dataH), 32'd1);
    check("reset.busy", 32'(xmit_busyH), 32'd0);
    check("reset.done", 32'(xmit_doneH), 32'd0);
    sys_rst_I = 1'b1;
    idle(5, "post_rst");

    // directed frames
    frame(8'hA5, 2'b00, 1'b0, 1'b0, -1, 1);  idle(3, "i1");
    frame(8'hA5, 2'b01, 1'b0, 1'b0, -1, 2);  idle(3, "i2");
    frame(8'hA5, 2'b10, 1'b0, 1'b0, -1, 3);  idle(3, "i3");
    frame(8'h3C, 2'b00, 1'b1, 1'b0, -1, 4);  idle(3, "i4");
    // back-to-back: second start bit right after the done cycle
    frame(8'h01, 2'b00, 1'b0, 1'b1, -1, 5);
    frame(8'h80, 2'b00, 1'b0, 1'b0, -1, 6);  idle(20, "i6");

    // randomized frames, mixing held and released requests
    for (int i = 0; i < 12; i++) begin
      h = (i < 11) ? 1'($urandom) : 1'b0;
      frame(DW'($urandom), 2'($urandom_range(0, 3)), 1'($urandom), h, -1, 10 + i);
      if (!h) idle($urandom_range(1, 4), $sformatf("ri%0d", i));
    end

    // reset mid-frame, then silence, then a clean frame
    frame(8'h5A, 2'b01, 1'b1, 1'b0, 70, 30);
    repeat (2) @(negedge sys_clk);
    sys_rst_I = 1'b1;
    idle(40, "after_abort");
    frame(8'hC3, 2'b10, 1'b0, 1'b0, -1, 31);
    idle(3, "i31");

`ifdef UART_TX_BREAK_EN
    begin
      int low_len;
      low_len = (1 + DW + 1) * BIT;  // 50-cycle request is below the minimum
      breakH = 1'b1; xmitH = 1'b1; xmit_dataH = 8'hFF;
      for (int k = 0; k <= low_len + BIT; k++) begin
        @(negedge sys_clk);
        check($sformatf("brk.line@%0d", k), 32'(uart_XMIT_dataH), 32'(k >= low_len));
        check($sformatf("brk.busy@%0d", k), 32'(xmit_busyH), 32'(k < low_len + BIT));
        check($sformatf("brk.done@%0d", k), 32'(xmit_doneH), 32'(k == low_len + BIT));
        if (k == 49) begin breakH = 1'b0; xmitH = 1'b0; end
      end
      idle(10, "post_brk");
    end
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
